key_search_sequencer: RTL and testbench
=======================================

// Module: key_search_sequencer
// PURPOSE
// Drives the mode/key inputs of the shared S-RAM controller to brute-force an RC4 key:
// for each candidate key it runs the init, shuffle and decrypt phases in order and reads
// their finish flags. Stops on decrypt success, range exhaustion or abort.
// Sits between top-level control (switches/buttons) and the RAM controller.
// PARAMETERS
// RAM_WIDTH   8         bits per key byte
// KEY_LENGTH  3         key bytes; counter width KW = KEY_LENGTH*RAM_WIDTH
// NUM_DEVICES 3         finish_bus width (0=init, 1=shuffle, 2=decrypt)
// KEY_START   24'h0     first candidate key (KW bits)
// KEY_END     24'h3FFFFF last candidate key, inclusive (KEY_END >= KEY_START)
// TIMEOUT     1<<16     per-phase watchdog limit in cycles (used only with macro)
// PORTS
// clk        in   1       clock
// reset      in   1       asynchronous active-high reset
// go         in   1       start search; sampled only in IDLE
// abort      in   1       cancel search; returns to IDLE
// finish_bus in   NUM_DEVICES  per-device done levels
// success    in   1       decrypt result valid when finish_bus[2]=1
// mode       out  6       phase select: 000_000 idle, 001_000 init, 010_000 shuffle, 011_000 decrypt
// key        out  [KEY_LENGTH-1:0][RAM_WIDTH-1:0]  current candidate; key[KEY_LENGTH-1] = MS byte
// busy       out  1       search in progress
// found      out  1       sticky: success seen; key holds winning key
// exhausted  out  1       sticky: KEY_END tried without success
// attempts   out  KW      completed decrypt attempts this search
// timeout_err out 1       watchdog tripped (tied 0 without macro)
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, mode=0, key=KEY_START, busy=found=exhausted=0,
//   attempts=0, timeout_err=0. All outputs registered.
// - States: IDLE, INIT, GAP_A, SHUF, GAP_B, DECR, NEXT, DONE.
// - IDLE: mode=0. go=1 -> INIT next cycle; key<=KEY_START, attempts<=0, found/exhausted/
//   timeout_err cleared, busy<=1. go while busy is ignored.
// - INIT: mode=001_000 until finish_bus[0]=1 -> GAP_A. SHUF: mode=010_000 until
//   finish_bus[1]=1 -> GAP_B. DECR: mode=011_000 until finish_bus[2]=1 -> NEXT.
// - GAP_A/GAP_B: exactly one cycle mode=0 so device start drops and finish clears.
// - Finish bits of non-active devices are ignored; success ignored unless finish_bus[2]=1
//   in DECR (sampled same cycle).
// - DECR exit: attempts<=attempts+1. success=1 -> DONE, found=1, key frozen.
//   else key==KEY_END -> DONE, exhausted=1. else NEXT.
// - NEXT: key<=key+1 (KW-bit, no wrap reachable since key<KEY_END), mode=0, -> INIT.
//   Per-key overhead: 3 idle cycles (GAP_A, GAP_B, NEXT).
// - DONE: mode=0, busy=0, flags/key held until next go.
// - abort=1 in any busy state: next cycle IDLE, mode=0, busy=0, key/attempts held,
//   found/exhausted stay 0. abort has priority over finish/success same cycle.
// - KEY_START==KEY_END: exactly one attempt.
// CONFIGURATION
// KEY_SEARCH_TIMEOUT_EN defined: cycle counter reset on each phase entry; if INIT/SHUF/DECR
//   lasts TIMEOUT cycles without finish -> DONE with timeout_err=1, busy=0, mode=0.
// KEY_SEARCH_TIMEOUT_EN undefined: no counter; phases wait indefinitely; timeout_err=0.
// TESTING
// - Reset mid-DECR -> next edge all outputs at reset values, mode=0.
// - go; model finishes after 5 cycles each, success on key 24'h000002 -> found=1,
//   key=24'h000002, attempts=3, mode sequence 001,0,010,0,011,0 per key.
// - KEY_START=KEY_END=24'h10, success never -> exhausted=1, attempts=1, busy=0.
// - abort in SHUF with finish_bus[1]=1 same cycle -> IDLE, GAP_B not entered, found=0.
// - finish_bus[2] and success pulsed during INIT -> ignored; no state change.
// - With KEY_SEARCH_TIMEOUT_EN, TIMEOUT=16, init never finishes -> timeout_err=1 after 16 cycles.

Source files
------------

// File: rtl/key_search_sequencer_if.sv
// Bus between the key search sequencer and the shared S-RAM controller:
// the phase select and candidate key go out, per-device finish levels and the decrypt verdict come back.
interface key_search_sequencer_if #(
    parameter int RAM_WIDTH   = 8,
    parameter int KEY_LENGTH  = 3,
    parameter int NUM_DEVICES = 3
);
    logic [5:0]                           mode;
    logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0] key;
    logic [NUM_DEVICES-1:0]               finish_bus;
    logic                                 success;

    modport master (output mode, output key, input finish_bus, input success);
    modport slave  (input mode, input key, output finish_bus, output success);
endinterface

// File: rtl/key_search_sequencer.sv
// Brute-force RC4 key sequencer: steps init/shuffle/decrypt on the RAM controller for each key.
// Optional per-phase watchdog is enabled by defining KEY_SEARCH_TIMEOUT_EN.
module key_search_sequencer #(
    parameter int                                RAM_WIDTH   = 8,
    parameter int                                KEY_LENGTH  = 3,
    parameter int                                NUM_DEVICES = 3,
    parameter logic [KEY_LENGTH*RAM_WIDTH-1:0]   KEY_START   = 24'h0,
    parameter logic [KEY_LENGTH*RAM_WIDTH-1:0]   KEY_END     = 24'h3FFFFF,
    parameter int                                TIMEOUT     = 1 << 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            go,
    input  logic                            abort,
    key_search_sequencer_if.master          ram,
    output logic                            busy,
    output logic                            found,
    output logic                            exhausted,
    output logic [KEY_LENGTH*RAM_WIDTH-1:0] attempts,
    output logic                            timeout_err
);
    localparam int KW = KEY_LENGTH * RAM_WIDTH;

    localparam logic [5:0] MODE_IDLE = 6'b000_000;
    localparam logic [5:0] MODE_INIT = 6'b001_000;
    localparam logic [5:0] MODE_SHUF = 6'b010_000;
    localparam logic [5:0] MODE_DECR = 6'b011_000;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_GAP_A, S_SHUF, S_GAP_B, S_DECR, S_NEXT, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    mode_q, mode_d;
    logic [KW-1:0] key_q, key_d;
    logic [KW-1:0] attempts_q, attempts_d;
    logic          busy_q, busy_d;
    logic          found_q, found_d;
    logic          exhausted_q, exhausted_d;

`ifdef KEY_SEARCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          timeout_q, timeout_d;
    logic          phase_timeout;

    assign phase_timeout = (state_q == S_INIT || state_q == S_SHUF || state_q == S_DECR)
                           && (timer_q == TW'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        attempts_d  = attempts_q;
        busy_d      = busy_q;
        found_d     = found_q;
        exhausted_d = exhausted_q;
`ifdef KEY_SEARCH_TIMEOUT_EN
        timeout_d   = timeout_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    state_d     = S_INIT;
                    key_d       = KEY_START;
                    attempts_d  = '0;
                    busy_d      = 1'b1;
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
`ifdef KEY_SEARCH_TIMEOUT_EN
                    timeout_d   = 1'b0;
`endif
                end
            end
            S_INIT:  if (ram.finish_bus[0]) state_d = S_GAP_A;
            S_GAP_A: state_d = S_SHUF;
            S_SHUF:  if (ram.finish_bus[1]) state_d = S_GAP_B;
            S_GAP_B: state_d = S_DECR;
            S_DECR: begin
                if (ram.finish_bus[2]) begin
                    attempts_d = attempts_q + 1'b1;
                    if (ram.success) begin
                        state_d = S_DONE;
                        found_d = 1'b1;
                        busy_d  = 1'b0;
                    end else if (key_q == KEY_END) begin
                        state_d     = S_DONE;
                        exhausted_d = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                key_d   = key_q + 1'b1;
                state_d = S_INIT;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef KEY_SEARCH_TIMEOUT_EN
        // A finish on the last allowed cycle still wins over the watchdog.
        if (phase_timeout && state_d == state_q) begin
            state_d   = S_DONE;
            busy_d    = 1'b0;
            timeout_d = 1'b1;
        end
        timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;
`endif

        // Abort overrides whatever the phase logic decided this cycle.
        if (abort && busy_q) begin
            state_d     = S_IDLE;
            key_d       = key_q;
            attempts_d  = attempts_q;
            busy_d      = 1'b0;
            found_d     = 1'b0;
            exhausted_d = 1'b0;
`ifdef KEY_SEARCH_TIMEOUT_EN
            timeout_d   = timeout_q;
`endif
        end

        case (state_d)
            S_INIT:  mode_d = MODE_INIT;
            S_SHUF:  mode_d = MODE_SHUF;
            S_DECR:  mode_d = MODE_DECR;
            default: mode_d = MODE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_IDLE;
            key_q       <= KEY_START;
            attempts_q  <= '0;
            busy_q      <= 1'b0;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
`ifdef KEY_SEARCH_TIMEOUT_EN
            timer_q     <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            key_q       <= key_d;
            attempts_q  <= attempts_d;
            busy_q      <= busy_d;
            found_q     <= found_d;
            exhausted_q <= exhausted_d;
`ifdef KEY_SEARCH_TIMEOUT_EN
            timer_q     <= timer_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign ram.mode  = mode_q;
    assign ram.key   = key_q;
    assign busy      = busy_q;
    assign found     = found_q;
    assign exhausted = exhausted_q;
    assign attempts  = attempts_q;
`ifdef KEY_SEARCH_TIMEOUT_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_key_search_sequencer.sv
// Directed bench for key_search_sequencer: reset, full search to a found key, exhaustion,
// abort/ignore corner cases, and the watchdog when KEY_SEARCH_TIMEOUT_EN is defined.
module tb_key_search_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic go_a = 1'b0, abort_a = 1'b0;
    logic go_b = 1'b0, abort_b = 1'b0;
    logic busy_a, found_a, exhausted_a, tmo_a;
    logic busy_b, found_b, exhausted_b, tmo_b;
    logic [23:0] attempts_a, attempts_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    key_search_sequencer_if #(.RAM_WIDTH(8), .KEY_LENGTH(3), .NUM_DEVICES(3)) ifa ();
    key_search_sequencer_if #(.RAM_WIDTH(8), .KEY_LENGTH(3), .NUM_DEVICES(3)) ifb ();

    key_search_sequencer #(.KEY_START(24'h0), .KEY_END(24'h3FFFFF), .TIMEOUT(16)) dut_a (
        .clk(clk), .reset(reset), .go(go_a), .abort(abort_a), .ram(ifa),
        .busy(busy_a), .found(found_a), .exhausted(exhausted_a),
        .attempts(attempts_a), .timeout_err(tmo_a)
    );

    key_search_sequencer #(.KEY_START(24'h10), .KEY_END(24'h10), .TIMEOUT(16)) dut_b (
        .clk(clk), .reset(reset), .go(go_b), .abort(abort_b), .ram(ifb),
        .busy(busy_b), .found(found_b), .exhausted(exhausted_b),
        .attempts(attempts_b), .timeout_err(tmo_b)
    );

    // RAM controller stand-in for dut_a: each phase finishes after 5 cycles, key 2 decrypts.
    logic       model_en = 1'b0;
    logic [2:0] fin_model = '0;
    logic [2:0] fin_man = '0;
    logic       succ_man = 1'b0;
    int         phase_cnt = 0;

    always @(posedge clk) begin
        if (ifa.mode == 6'h08 || ifa.mode == 6'h10 || ifa.mode == 6'h18) begin
            phase_cnt <= phase_cnt + 1;
            if (phase_cnt == 4) begin
                case (ifa.mode)
                    6'h08:   fin_model <= 3'b001;
                    6'h10:   fin_model <= 3'b010;
                    default: fin_model <= 3'b100;
                endcase
            end
        end else begin
            phase_cnt <= 0;
            fin_model <= '0;
        end
    end

    assign ifa.finish_bus = model_en ? fin_model : fin_man;
    assign ifa.success    = model_en ? (fin_model[2] && (ifa.key == 24'h000002)) : succ_man;

    // dut_b's devices finish instantly and never report success.
    assign ifb.finish_bus = {ifb.mode == 6'h18, ifb.mode == 6'h10, ifb.mode == 6'h08};
    assign ifb.success    = 1'b0;

    // Mode-change and per-key logs for dut_a.
    logic        log_en = 1'b0;
    logic [5:0]  last_mode = '0;
    logic [5:0]  mode_log[$];
    logic [23:0] key_log[$];

    always @(negedge clk) begin
        if (log_en && ifa.mode != last_mode) begin
            mode_log.push_back(ifa.mode);
            if (ifa.mode == 6'h08) key_log.push_back(ifa.key);
            last_mode <= ifa.mode;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [5:0] exp_seq[6];
    int         wait_n;

    initial begin
        exp_seq = '{6'h08, 6'h00, 6'h10, 6'h00, 6'h18, 6'h00};

        // Reset state
        tick(2);
        reset = 1'b0;
        tick(1);
        check("rst_mode", ifa.mode, 6'h00);
        check("rst_key", ifa.key, 24'h0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_found", found_a, 1'b0);
        check("rst_exh", exhausted_a, 1'b0);
        check("rst_att", attempts_a, 24'h0);
        check("rst_tmo", tmo_a, 1'b0);
        check("rst_key_b", ifb.key, 24'h10);
        $display("step reset: done");

        // Single-key range exhausts after one attempt
        go_b = 1'b1;
        tick(1);
        go_b = 1'b0;
        check("b_start_busy", busy_b, 1'b1);
        wait_n = 0;
        while (!(exhausted_b || found_b) && wait_n < 50) begin tick(1); wait_n++; end
        check("b_exh", exhausted_b, 1'b1);
        check("b_found", found_b, 1'b0);
        check("b_att", attempts_b, 24'h1);
        check("b_busy", busy_b, 1'b0);
        check("b_key", ifb.key, 24'h10);
        check("b_mode", ifb.mode, 6'h00);
        $display("step exhaust: attempts=%0d exhausted=%0b", attempts_b, exhausted_b);

        // Full search: success on key 2
        model_en = 1'b1;
        log_en   = 1'b1;
        go_a     = 1'b1;
        tick(1);
        go_a = 1'b0;
        wait_n = 0;
        while (!(found_a || exhausted_a) && wait_n < 600) begin tick(1); wait_n++; end
        tick(1);
        log_en = 1'b0;
        check("srch_found", found_a, 1'b1);
        check("srch_exh", exhausted_a, 1'b0);
        check("srch_key", ifa.key, 24'h000002);
        check("srch_att", attempts_a, 24'h3);
        check("srch_busy", busy_a, 1'b0);
        check("srch_mode", ifa.mode, 6'h00);
        check("srch_log_len", mode_log.size(), 18);
        for (int i = 0; i < 18; i++) check($sformatf("srch_mode_seq%0d", i), mode_log[i], exp_seq[i % 6]);
        check("srch_keys_len", key_log.size(), 3);
        for (int i = 0; i < 3; i++) check($sformatf("srch_key_seq%0d", i), key_log[i], i);
        $display("step search: key=%0h attempts=%0d found=%0b", ifa.key, attempts_a, found_a);

        // Reset in the middle of the second key's decrypt phase
        go_a = 1'b1;
        tick(1);
        go_a = 1'b0;
        wait_n = 0;
        while (!(ifa.mode == 6'h18 && attempts_a == 24'h1) && wait_n < 600) begin tick(1); wait_n++; end
        check("mid_reached_decr", ifa.mode, 6'h18);
        #2 reset = 1'b1;
        tick(1);
        check("mid_mode", ifa.mode, 6'h00);
        check("mid_key", ifa.key, 24'h0);
        check("mid_att", attempts_a, 24'h0);
        check("mid_busy", busy_a, 1'b0);
        check("mid_found", found_a, 1'b0);
        check("mid_exh", exhausted_a, 1'b0);
        check("mid_tmo", tmo_a, 1'b0);
        model_en = 1'b0;
        reset = 1'b0;
        tick(1);
        $display("step reset-mid-decrypt: mode=%0h busy=%0b", ifa.mode, busy_a);

        // Manual handshake: stray decrypt finish/success during INIT is ignored
        go_a = 1'b1;
        tick(1);
        go_a = 1'b0;
        check("man_init_mode", ifa.mode, 6'h08);
        check("man_init_busy", busy_a, 1'b1);
        fin_man = 3'b100; succ_man = 1'b1;
        tick(1);
        check("ign_mode", ifa.mode, 6'h08);
        check("ign_found", found_a, 1'b0);
        check("ign_att", attempts_a, 24'h0);
        fin_man = 3'b000; succ_man = 1'b0;
        $display("step ignore: mode=%0h found=%0b", ifa.mode, found_a);

        // One failed key, then on to the next
        fin_man = 3'b001; tick(1); check("gapa_mode", ifa.mode, 6'h00);
        fin_man = 3'b000; tick(1); check("shuf_mode", ifa.mode, 6'h10);
        fin_man = 3'b010; tick(1); check("gapb_mode", ifa.mode, 6'h00);
        fin_man = 3'b000; tick(1); check("decr_mode", ifa.mode, 6'h18);
        fin_man = 3'b100; tick(1);
        check("next_mode", ifa.mode, 6'h00);
        check("next_att", attempts_a, 24'h1);
        check("next_key", ifa.key, 24'h0);
        fin_man = 3'b000; tick(1);
        check("k1_mode", ifa.mode, 6'h08);
        check("k1_key", ifa.key, 24'h1);
        $display("step next-key: key=%0h attempts=%0d", ifa.key, attempts_a);

        // Abort in SHUF with shuffle finish in the same cycle
        fin_man = 3'b001; tick(1);
        fin_man = 3'b000; tick(1);
        check("ab_shuf_mode", ifa.mode, 6'h10);
        fin_man = 3'b010; abort_a = 1'b1;
        tick(1);
        check("ab_mode", ifa.mode, 6'h00);
        check("ab_busy", busy_a, 1'b0);
        check("ab_found", found_a, 1'b0);
        check("ab_exh", exhausted_a, 1'b0);
        check("ab_key", ifa.key, 24'h1);
        check("ab_att", attempts_a, 24'h1);
        fin_man = 3'b000; abort_a = 1'b0;
        tick(1);
        check("ab_stay_idle", ifa.mode, 6'h00);
        check("ab_stay_busy", busy_a, 1'b0);
        $display("step abort: mode=%0h busy=%0b key=%0h", ifa.mode, busy_a, ifa.key);

`ifdef KEY_SEARCH_TIMEOUT_EN
        // INIT never finishes: watchdog fires after 16 cycles
        go_a = 1'b1;
        tick(1);
        go_a = 1'b0;
        tick(15);
        check("tmo_pre_mode", ifa.mode, 6'h08);
        check("tmo_pre_flag", tmo_a, 1'b0);
        tick(1);
        check("tmo_mode", ifa.mode, 6'h00);
        check("tmo_flag", tmo_a, 1'b1);
        check("tmo_busy", busy_a, 1'b0);
        $display("step timeout: timeout_err=%0b", tmo_a);
`else
        go_a = 1'b1;
        tick(1);
        go_a = 1'b0;
        tick(40);
        check("no_tmo_mode", ifa.mode, 6'h08);
        check("no_tmo_flag", tmo_a, 1'b0);
        $display("step no-watchdog: mode=%0h timeout_err=%0b", ifa.mode, tmo_a);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
